// File: rtl/fetch_decode_queue_pkg.sv
// Shared fetch/decode types: the fetch-queue entry payload and default queue depth.
package fetch_decode_queue_pkg;

    localparam int unsigned ADDR_WIDTH        = 32;
    localparam int unsigned INSN_WIDTH        = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic                  isNextPcPredicted;
        logic [ADDR_WIDTH-1:0] predictedNextPC;
        logic                  isBranchTakenPredicted;
    } BranchPredict;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INSN_WIDTH-1:0] instruction;
        BranchPredict          branchPredict;
    } FetchQueueEntry;

    localparam int unsigned FQE_W = $bits(FetchQueueEntry);

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch -> queue -> decode handshake bundle.
//   enq_valid/enq_ready/enq_entry : fetch side
//   deq_valid/deq_ready/deq_entry : decode side
// slave  : the queue itself; master : the surrounding fetch/decode logic.
interface fetch_decode_queue_if;
    import fetch_decode_queue_pkg::*;

    logic           enq_valid;
    logic           enq_ready;
    FetchQueueEntry enq_entry;
    logic           deq_valid;
    logic           deq_ready;
    FetchQueueEntry deq_entry;

    modport slave (
        input  enq_valid, enq_entry, deq_ready,
        output enq_ready, deq_valid, deq_entry
    );

    modport master (
        output enq_valid, enq_entry, deq_ready,
        input  enq_ready, deq_valid, deq_entry
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// Fetch-queue storage: DEPTH x WIDTH, one synchronous write port, one async read port.
// Contents are intentionally not reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : read data (combinational)
module fetch_queue_ram
    import fetch_decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
    parameter int unsigned WIDTH = FQE_W
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode; decouples decode stalls from IMem/BTB
// lookup. A controller flush drops every entry.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue zero-latency bypass).
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   flush  : synchronous flush, highest priority
//   fq     : enq/deq handshake bundle (slave side)
//   count  : occupancy, 0..DEPTH
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fetch_decode_queue_if.slave    fq,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned PTR_W     = PTR_WIDTH + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t           wr_ptr_q, wr_ptr_d;
    ptr_t           rd_ptr_q, rd_ptr_d;
    logic           empty_c, full_c;
    logic           wr_en_c, rd_adv_c, bypass_c;
    FetchQueueEntry rd_data;

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (FQE_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en_c),
        .waddr_i (wr_ptr_q[PTR_WIDTH-1:0]),
        .wdata_i (fq.enq_entry),
        .raddr_i (rd_ptr_q[PTR_WIDTH-1:0]),
        .rdata_o (rd_data)
    );

    // Handshake outputs and pointer next-state; flush overrides everything.
    always_comb begin
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                   (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
        bypass_c = 1'b0;

        fq.enq_ready = !full_c && !flush;
        fq.deq_valid = !empty_c && !flush;
        fq.deq_entry = fq.deq_valid ? rd_data : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue: present fetch's entry directly; if decode takes it, skip storage.
        if (empty_c && !flush) begin
            fq.deq_valid = fq.enq_valid;
            fq.deq_entry = fq.enq_valid ? fq.enq_entry : '0;
            bypass_c     = fq.enq_valid && fq.deq_ready;
        end
`endif

        wr_en_c  = fq.enq_valid && fq.enq_ready && !bypass_c;
        rd_adv_c = fq.deq_valid && fq.deq_ready && !empty_c;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_c);
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_adv_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Modular difference gives occupancy even across the wrap bit.
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue (default build or FETCH_QUEUE_BYPASS_EN).
module tb_fetch_decode_queue;
    import fetch_decode_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    fetch_decode_queue_if fq_if();

    int n_checks;
    int n_err;

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .fq    (fq_if),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic FetchQueueEntry mk(input logic [31:0] pc);
        FetchQueueEntry e;
        e.pc                                  = pc;
        e.instruction                         = 32'h0000_0013 | (pc << 7);
        e.branchPredict.isNextPcPredicted     = pc[2];
        e.branchPredict.predictedNextPC       = pc + 32'h100;
        e.branchPredict.isBranchTakenPredicted = pc[3] ^ pc[4];
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents as a plain list.
    FetchQueueEntry mq[$];

    function automatic logic m_bypass_path();
        return BYP && (mq.size() == 0) && !flush;
    endfunction

    function automatic logic m_deq_valid();
        if (m_bypass_path()) return fq_if.enq_valid;
        return !flush && (mq.size() > 0);
    endfunction

    function automatic FetchQueueEntry m_deq_entry();
        if (!m_deq_valid()) return '0;
        if (m_bypass_path()) return fq_if.enq_entry;
        return mq[0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            logic enq_f, deq_f, byp;
            enq_f = fq_if.enq_valid && (mq.size() < DEPTH);
            deq_f = m_deq_valid() && fq_if.deq_ready;
            byp   = m_bypass_path() && enq_f && deq_f;
            if (!byp) begin
                if (deq_f) void'(mq.pop_front());
                if (enq_f) mq.push_back(fq_if.enq_entry);
            end
        end
    end

    // Per-cycle comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        chk("enq_ready", 128'(fq_if.enq_ready), 128'(!flush && (mq.size() < DEPTH)));
        chk("deq_valid", 128'(fq_if.deq_valid), 128'(m_deq_valid()));
        chk("deq_entry", 128'(fq_if.deq_entry), 128'(m_deq_entry()));
        chk("count",     128'(count),           128'(mq.size()));
    end

    task automatic drive(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
        fq_if.enq_valid = ev;
        fq_if.enq_entry = ev ? mk(pc) : '0;
        fq_if.deq_ready = dr;
        flush           = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // 1. reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_deq_valid", 128'(fq_if.deq_valid), 128'd0);
        chk("rst_enq_ready", 128'(fq_if.enq_ready), 128'd1);
        chk("rst_count",     128'(count),           128'd0);
        chk("rst_deq_entry", 128'(fq_if.deq_entry), 128'd0);
        rst = 1'b1;
        tick();
        chk("idle_count", 128'(count), 128'd0);

        // 2. fill to full, fifth enqueue refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        #1;
        chk("full_count",     128'(count),           128'd4);
        chk("full_enq_ready", 128'(fq_if.enq_ready), 128'd0);
        tick();
        chk("refused_count",  128'(count),           128'd4);

        // 3. drain in order, payload bit-exact
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc",    128'(fq_if.deq_entry.pc), 128'(4 * i));
            chk("drain_entry", 128'(fq_if.deq_entry),    128'(mk(32'(4 * i))));
            tick();
        end
        chk("drained_count", 128'(count), 128'd0);

        // 4. steady enq+deq with one entry resident
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h204 + 32'(4 * i), 1'b1, 1'b0);
            #1;
            chk("stream_count", 128'(count), 128'd1);
            chk("stream_pc",    128'(fq_if.deq_entry.pc), 128'(32'h200 + 32'(4 * i)));
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("stream_drained", 128'(count), 128'd0);

        // 5. flush with two entries held and a concurrent enqueue
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        #1;
        chk("flush_deq_valid", 128'(fq_if.deq_valid), 128'd0);
        chk("flush_enq_ready", 128'(fq_if.enq_ready), 128'd0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("post_flush_count", 128'(count),           128'd0);
        chk("post_flush_valid", 128'(fq_if.deq_valid), 128'd0);
        repeat (2) tick();

        // 6. empty queue, enqueue with decode ready
        drive(1'b1, 32'h80, 1'b1, 1'b0);
        #1;
        if (BYP) begin
            chk("byp_same_cycle_pc", 128'(fq_if.deq_entry.pc), 128'h80);
            chk("byp_same_cycle_v",  128'(fq_if.deq_valid),    128'd1);
        end else begin
            chk("nobyp_same_cycle_v", 128'(fq_if.deq_valid), 128'd0);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        if (BYP) begin
            chk("byp_count",      128'(count),           128'd0);
            chk("byp_next_valid", 128'(fq_if.deq_valid), 128'd0);
        end else begin
            chk("nobyp_next_pc", 128'(fq_if.deq_entry.pc), 128'h80);
            chk("nobyp_next_v",  128'(fq_if.deq_valid),    128'd1);
        end
        tick();
        chk("final_count", 128'(count), 128'd0);

        // reset mid-operation discards held entries
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        repeat (2) tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_count", 128'(count),           128'd0);
        chk("midrst_valid", 128'(fq_if.deq_valid), 128'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
